// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with an optional valid-qualified output register.
module full_adder #(
  parameter int WIDTH  = 1,
  parameter bit REG_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic [WIDTH-1:0] sout_q,
  output logic             cout_q,
  output logic             out_valid
);
  logic [WIDTH:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_p;
    assign w_p        = ain[i] ^ bin[i];
    assign sout[i]    = w_p ^ w_c[i];
    assign w_c[i+1]   = (ain[i] & bin[i]) | (w_c[i] & w_p);
  end
  assign cout = w_c[WIDTH];
  if (REG_EN) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_sum  <= sout;
          r_cout <= cout;
        end
      end
    end
    assign sout_q    = r_sum;
    assign cout_q    = r_cout;
    assign out_valid = r_valid;
  end else begin : g_noreg
    assign sout_q    = '0;
    assign cout_q    = 1'b0;
    assign out_valid = 1'b0;
  end
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for full_adder at WIDTH 1, 4 (unregistered), 8 and 16.
module tb_full_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        c1, a1, b1, v1, s1, co1, sq1, cq1, ov1;
  logic        c4, v4, co4, cq4, ov4;
  logic [3:0]  a4, b4, s4, sq4;
  logic        c8, v8, co8, cq8, ov8;
  logic [7:0]  a8, b8, s8, sq8;
  logic        c16, v16, co16, cq16, ov16;
  logic [15:0] a16, b16, s16, sq16;

  full_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .cin(c1), .ain(a1), .bin(b1), .in_valid(v1),
    .sout(s1), .cout(co1), .sout_q(sq1), .cout_q(cq1), .out_valid(ov1));
  full_adder #(.WIDTH(4), .REG_EN(0)) u4 (.clk(clk), .rst(rst), .cin(c4), .ain(a4), .bin(b4), .in_valid(v4),
    .sout(s4), .cout(co4), .sout_q(sq4), .cout_q(cq4), .out_valid(ov4));
  full_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .cin(c8), .ain(a8), .bin(b8), .in_valid(v8),
    .sout(s8), .cout(co8), .sout_q(sq8), .cout_q(cq8), .out_valid(ov8));
  full_adder #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .cin(c16), .ain(a16), .bin(b16), .in_valid(v16),
    .sout(s16), .cout(co16), .sout_q(sq16), .cout_q(cq16), .out_valid(ov16));

  logic [16:0] q[$];
  int          n_pushed = 0;
  int          n_popped = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set u16 inputs, check the combinational sum, queue the expected registered result, clock once.
  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
    logic [16:0] ref_sum;
    a16 = a; b16 = b; c16 = c; v16 = v;
    ref_sum = 17'(a) + 17'(b) + 17'(c);
    #1;
    chk("comb16", {co16, s16}, ref_sum);
    if (v && !rst) begin
      q.push_back(ref_sum);
      n_pushed++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ov16) begin
      if (q.size() == 0) chk("ov16_unexpected", 1, 0);
      else begin
        chk("reg16", {cq16, sq16}, q.pop_front());
        n_popped++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    {c1, a1, b1, v1} = '0;
    {c4, a4, b4, v4} = '0;
    {c8, a8, b8, v8} = '0;
    {c16, a16, b16, v16} = '0;
    for (int k = 0; k < 8; k++) begin
      {c1, a1, b1} = 3'(k);
      #1;
      chk($sformatf("tt1_%0d", k), {co1, s1}, tt[k]);
      #9;
    end
    step();
    chk("rst_q16", {cq16, sq16, ov16}, 0);
    chk("rst_q1", {cq1, sq1, ov1}, 0);
    rst = 1'b0;
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0;
    #1 chk("w8_ff_01", {co8, s8}, 9'h100);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    #1 chk("w8_ff_ff_1", {co8, s8}, 9'h1FF);
    step();
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
    step();
    chk("w1_capture", {sq1, cq1, ov1}, 3'b011);
    v1 = 1'b0; a1 = 1'b0;
    step();
    chk("w1_hold", {sq1, cq1, ov1}, 3'b010);
    a4 = 4'hF; b4 = 4'h3; c4 = 1'b1; v4 = 1'b1;
    step();
    chk("noreg_comb", {co4, s4}, 5'h13);
    chk("noreg_q", {cq4, sq4, ov4}, 0);
    drive16(16'd3, 16'd4, 1'b0, 1'b1);
    rst = 1'b1;
    drive16(16'd5, 16'd7, 1'b0, 1'b1);
    chk("rst_prio", {cq16, sq16, ov16}, 0);
    chk("rst_comb", {co16, s16}, 17'd12);
    rst = 1'b0;
    drive16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    drive16(16'h8000, 16'h8000, 1'b0, 1'b1);
    drive16(16'h1234, 16'h4321, 1'b1, 1'b1);
    drive16(16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("stream_no_bubble", n_popped, n_pushed - 1);
    for (int k = 0; k < 1000; k++)
      drive16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    drive16(16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("drain", q.size(), 0);
    chk("pop_count", n_popped, n_pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 1, SHALL set the operand width in bits; legal range 1..64.
REQ-003 Parameter REG_EN, default 1, SHALL include the registered output path when 1; when 0, the registered outputs SHALL be tied to 0.
REQ-004 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port cin, input, 1 bit, SHALL be the carry-in.
REQ-007 Port ain, input, WIDTH bits, SHALL be operand A (unsigned).
REQ-008 Port bin, input, WIDTH bits, SHALL be operand B (unsigned).
REQ-009 Port in_valid, input, 1 bit, SHALL qualify the operands for the registered path.
REQ-010 Port sout, output, WIDTH bits, SHALL be the combinational sum.
REQ-011 Port cout, output, 1 bit, SHALL be the combinational carry-out.
REQ-012 Port sout_q, output, WIDTH bits, SHALL be the registered sum.
REQ-013 Port cout_q, output, 1 bit, SHALL be the registered carry-out.
REQ-014 Port out_valid, output, 1 bit, SHALL mark sout_q/cout_q as holding a new result.

Function
REQ-015 {cout, sout} SHALL equal ain + bin + cin, computed at WIDTH+1 bits, with zero latency and no dependence on clk, rst or in_valid.
REQ-016 For WIDTH=1, sout SHALL equal ain XOR bin XOR cin, and cout SHALL equal (ain AND bin) OR (cin AND (ain XOR bin)).
REQ-017 The sum SHALL be built as a ripple of 1-bit full-adder cells:
- bit i takes carry from bit i-1
- bit 0 takes cin
- cout is the carry out of bit WIDTH-1.
REQ-018 On a rising clk edge with rst=0 and in_valid=1, sout_q/cout_q SHALL capture the current sout/cout, and out_valid SHALL be 1 on the following cycle (latency 1).
REQ-019 On a rising clk edge with rst=0 and in_valid=0, sout_q/cout_q SHALL hold their values, and out_valid SHALL be 0 on the following cycle.
REQ-020 Back-to-back in_valid cycles SHALL each produce one result, one cycle apart, with no bubbles (throughput 1 per cycle).
REQ-021 Wrap-around: all-ones + all-ones + cin=1 SHALL give sout = all ones and cout = 1; no overflow flag exists beyond cout.
REQ-022 Inputs X/Z SHALL be outside scope; no internal state other than sout_q, cout_q and out_valid SHALL exist.

Reset
REQ-023 On a rising clk edge with rst=1:
- sout_q, cout_q and out_valid SHALL become 0
- rst SHALL take priority over in_valid.
REQ-024 The combinational sout/cout SHALL be unaffected by rst.
REQ-025 Reset asserted mid-stream SHALL discard any pending result; the first valid after rst deasserts SHALL appear one cycle later, as in REQ-018.

Verification
REQ-026 WIDTH=1 exhaustive truth table, 8 combinations of {cin, ain, bin} stepped every 10 time units -> {cout, sout}:
- 000->00, 001->01, 010->01, 011->10
- 100->01, 101->10, 110->10, 111->11.
REQ-027 WIDTH=8: ain=8'hFF, bin=8'h01, cin=0 -> sout=8'h00, cout=1; then ain=8'hFF, bin=8'hFF, cin=1 -> sout=8'hFF, cout=1.
REQ-028 Registered path: in_valid=1 with ain=1, bin=1, cin=0 at edge N -> sout_q=0, cout_q=1, out_valid=1 after edge N; in_valid=0 at edge N+1 -> values held, out_valid=0.
REQ-029 Reset: assert rst together with in_valid=1 at edge N -> after edge N, sout_q=0, cout_q=0, out_valid=0, while sout/cout still track the inputs combinationally.
REQ-030 Stream: 4 consecutive valid operand sets -> 4 consecutive out_valid=1 cycles with matching results; random WIDTH=16 vectors (1000 vectors) -> results match the reference model ain+bin+cin.
